// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and widths for the per-frame game logic blocks
package game_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        PRESSED   = 2'd2,
        RELEASING = 2'd3
    } btn_state_t;

    localparam int COORD_W = 10;
    localparam int LIFT_W  = 6;

endpackage

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - synchronizes VSync into the system clock and emits a one-cycle tick per rising edge
module frame_tick_gen (
    input  logic clk,
    input  logic rst,
    input  logic frame_clk,
    output logic tick
);

    logic sync0;
    logic sync1;
    logic sync1_d;

    // Tick lands three clk edges after the VSync rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0   <= 1'b0;
            sync1   <= 1'b0;
            sync1_d <= 1'b0;
            tick    <= 1'b0;
        end else begin
            sync0   <= frame_clk;
            sync1   <= sync0;
            sync1_d <= sync1;
            tick    <= sync1 & ~sync1_d;
        end
    end

endmodule

// File: rtl/button_press_ctrl.sv
// rtl/button_press_ctrl.sv - filtered floor-button press detection and platform lift offset, advanced once per frame
module button_press_ctrl
    import game_pkg::*;
#(
    parameter int BTN_X          = 142,
    parameter int BTN_Y          = 322,
    parameter int BTN_W          = 20,
    parameter int BTN_H          = 10,
    parameter int PRESS_FRAMES   = 2,
    parameter int RELEASE_FRAMES = 4,
    parameter int LIFT_MAX       = 40
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic [COORD_W-1:0] p0_x,
    input  logic [COORD_W-1:0] p0_y,
    input  logic [COORD_W-1:0] p1_x,
    input  logic [COORD_W-1:0] p1_y,
    output logic               is_button_push,
    output logic [LIFT_W-1:0]  lift_offset,
    output logic               lift_moving
);

    localparam logic [COORD_W:0] X_LO     = (COORD_W+1)'(BTN_X);
    localparam logic [COORD_W:0] X_HI     = (COORD_W+1)'(BTN_X + BTN_W);
    localparam logic [COORD_W:0] Y_LO     = (COORD_W+1)'(BTN_Y);
    localparam logic [COORD_W:0] Y_HI     = (COORD_W+1)'(BTN_Y + BTN_H);
    localparam logic [2:0]       PRESS_N  = 3'(PRESS_FRAMES);
    localparam logic [2:0]       RELEASE_N = 3'(RELEASE_FRAMES);
    localparam logic [LIFT_W-1:0] LIFT_TOP = LIFT_W'(LIFT_MAX);

    // One bit of headroom keeps the box edges from wrapping near the top of the coordinate range.
    function automatic logic hit(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
        logic [COORD_W:0] xw;
        logic [COORD_W:0] yw;
        xw = {1'b0, x};
        yw = {1'b0, y};
        return (xw >= X_LO) && (xw < X_HI) && (yw >= Y_LO) && (yw < Y_HI);
    endfunction

    logic              tick;
    logic              occ;
    btn_state_t        state;
    btn_state_t        nxt_state;
    logic [2:0]        cnt;
    logic [2:0]        nxt_cnt;
    logic              nxt_push;
    logic [LIFT_W-1:0] nxt_lift;

    frame_tick_gen u_tick (
        .clk       (Clk),
        .rst       (Reset),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    always_comb begin
        occ       = hit(p0_x, p0_y) | hit(p1_x, p1_y);
        nxt_state = state;
        nxt_cnt   = cnt;
        unique case (state)
            IDLE: begin
                if (occ) begin
                    if (PRESS_N == 3'd1) begin
                        nxt_state = PRESSED;
                        nxt_cnt   = 3'd0;
                    end else begin
                        nxt_state = ARMING;
                        nxt_cnt   = 3'd1;
                    end
                end
            end
            ARMING: begin
                if (!occ) begin
                    nxt_state = IDLE;
                    nxt_cnt   = 3'd0;
                end else if (cnt + 3'd1 == PRESS_N) begin
                    nxt_state = PRESSED;
                    nxt_cnt   = 3'd0;
                end else begin
                    nxt_cnt = cnt + 3'd1;
                end
            end
            PRESSED: begin
                if (!occ) begin
                    if (RELEASE_N == 3'd1) begin
                        nxt_state = IDLE;
                        nxt_cnt   = 3'd0;
                    end else begin
                        nxt_state = RELEASING;
                        nxt_cnt   = 3'd1;
                    end
                end
            end
            RELEASING: begin
                if (occ) begin
                    nxt_state = PRESSED;
                    nxt_cnt   = 3'd0;
                end else if (cnt + 3'd1 == RELEASE_N) begin
                    nxt_state = IDLE;
                    nxt_cnt   = 3'd0;
                end else begin
                    nxt_cnt = cnt + 3'd1;
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_cnt   = 3'd0;
            end
        endcase

        nxt_push = (nxt_state == PRESSED) || (nxt_state == RELEASING);
        nxt_lift = lift_offset;
        if (nxt_push && (lift_offset < LIFT_TOP)) begin
            nxt_lift = lift_offset + LIFT_W'(1);
        end else if (!nxt_push && (lift_offset != '0)) begin
            nxt_lift = lift_offset - LIFT_W'(1);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state          <= IDLE;
            cnt            <= 3'd0;
            is_button_push <= 1'b0;
            lift_offset    <= '0;
            lift_moving    <= 1'b0;
        end else if (tick) begin
            state          <= nxt_state;
            cnt            <= nxt_cnt;
            is_button_push <= nxt_push;
            lift_offset    <= nxt_lift;
            lift_moving    <= (nxt_lift != lift_offset);
        end
    end

endmodule

// File: tb/tb_button_press_ctrl.sv
// tb/tb_button_press_ctrl.sv - self-checking bench for button_press_ctrl against a frame-level reference model
module tb_button_press_ctrl;

    localparam int PRESS   = 2;
    localparam int RELEASE = 4;
    localparam int LMAX    = 40;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic [9:0] p0_x = '0;
    logic [9:0] p0_y = '0;
    logic [9:0] p1_x = '0;
    logic [9:0] p1_y = '0;
    logic       is_button_push;
    logic [5:0] lift_offset;
    logic       lift_moving;

    int checks = 0;
    int errors = 0;

    // Reference model: run lengths of occupied/empty frames and an integer lift height.
    int m_pressed = 0;
    int m_run     = 0;
    int m_lift    = 0;
    int m_moving  = 0;

    button_press_ctrl dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .frame_clk      (frame_clk),
        .p0_x           (p0_x),
        .p0_y           (p0_y),
        .p1_x           (p1_x),
        .p1_y           (p1_y),
        .is_button_push (is_button_push),
        .lift_offset    (lift_offset),
        .lift_moving    (lift_moving)
    );

    always #10 Clk = ~Clk;

    function automatic int on_btn(input int x, input int y);
        return (x >= 142 && x < 162 && y >= 322 && y < 332) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_pressed = 0;
        m_run     = 0;
        m_lift    = 0;
        m_moving  = 0;
    endtask

    task automatic model_frame(input int occ);
        int old_lift;
        if (!m_pressed) begin
            m_run = occ ? m_run + 1 : 0;
            if (m_run == PRESS) begin
                m_pressed = 1;
                m_run     = 0;
            end
        end else begin
            m_run = occ ? 0 : m_run + 1;
            if (m_run == RELEASE) begin
                m_pressed = 0;
                m_run     = 0;
            end
        end
        old_lift = m_lift;
        if (m_pressed && m_lift < LMAX) m_lift = m_lift + 1;
        else if (!m_pressed && m_lift > 0) m_lift = m_lift - 1;
        m_moving = (m_lift != old_lift) ? 1 : 0;
    endtask

    task automatic check_outputs(input string tag);
        checks++;
        assert (is_button_push === 1'(m_pressed)) else begin
            errors++;
            $error("FAIL %s push got %0b exp %0d", tag, is_button_push, m_pressed);
        end
        checks++;
        assert (lift_offset === 6'(m_lift)) else begin
            errors++;
            $error("FAIL %s lift got %0d exp %0d", tag, lift_offset, m_lift);
        end
        checks++;
        assert (lift_moving === 1'(m_moving)) else begin
            errors++;
            $error("FAIL %s moving got %0b exp %0d", tag, lift_moving, m_moving);
        end
    endtask

    task automatic do_frame(input int x0, input int y0, input int x1, input int y1, input string tag);
        p0_x = 10'(x0);
        p0_y = 10'(y0);
        p1_x = 10'(x1);
        p1_y = 10'(y1);
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (6) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
        model_frame(on_btn(x0, y0) | on_btn(x1, y1));
        check_outputs(tag);
    endtask

    initial begin
        int guard;
        int rx;
        int ry;

        // Reset held while VSync keeps toggling.
        for (int i = 0; i < 4; i++) begin
            repeat (3) @(negedge Clk);
            frame_clk = ~frame_clk;
        end
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
        model_reset();
        check_outputs("reset");
        Reset = 1'b0;

        for (int i = 0; i < 5; i++) do_frame(0, 0, 0, 0, "idle");

        for (int i = 0; i < 45; i++) do_frame(150, 325, 0, 0, "press_hold");

        for (int i = 0; i < 3; i++) do_frame(0, 0, 0, 0, "short_leave");
        do_frame(150, 325, 0, 0, "return");
        for (int i = 0; i < 44; i++) do_frame(0, 0, 0, 0, "release");

        for (int i = 0; i < 3; i++) do_frame(141, 325, 0, 0, "edge_left");
        for (int i = 0; i < 3; i++) do_frame(162, 325, 0, 0, "edge_right");
        for (int i = 0; i < 3; i++) do_frame(150, 332, 0, 0, "edge_bottom");
        for (int i = 0; i < 3; i++) do_frame(161, 331, 0, 0, "edge_inner");
        for (int i = 0; i < 5; i++) do_frame(0, 0, 0, 0, "drop");

        for (int i = 0; i < 4; i++) do_frame(150, 325, 145, 323, "both");
        for (int i = 0; i < 6; i++) do_frame(0, 0, 145, 323, "p1_only");
        for (int i = 0; i < 6; i++) do_frame(0, 0, 0, 0, "both_gone");

        // Build lift up to 20, then hit reset between clock edges.
        guard = 0;
        while ((m_lift != 20 || !m_pressed) && guard < 100) begin
            do_frame(150, 325, 0, 0, "to_twenty");
            guard++;
        end
        checks++;
        assert (guard < 100) else begin
            errors++;
            $error("FAIL lift_to_twenty got %0d exp 20", m_lift);
        end
        @(negedge Clk);
        #3 Reset = 1'b1;
        #1;
        model_reset();
        check_outputs("async_reset");
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        do_frame(150, 325, 0, 0, "post_reset_1");
        do_frame(150, 325, 0, 0, "post_reset_2");

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                rx = 0;
                ry = 0;
            end else begin
                rx = $urandom_range(136, 168);
                ry = $urandom_range(318, 336);
            end
            if ($urandom_range(0, 3) == 0) do_frame(rx, ry, $urandom_range(140, 164), $urandom_range(320, 334), "rand2");
            else do_frame(rx, ry, 0, 0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
